aes_apb2periph: RTL and testbench
=================================

# aes_apb2periph

Bridge from a single APB3 slave port to the HWPE peripheral (periph) request/grant/response port of the AES engine wrapper. It sits directly upstream of the AES engine's periph slave port and lets an APB host program and poll the AES register file. Each APB transfer becomes exactly one periph transaction. The APB transfer completes only after the matching periph response has been returned.

## Interface
Parameters:
- ID, 10, width of periph_id_o / periph_r_id_i
- ID_VAL, 1, constant ID driven on periph_id_o; responses with any other r_id are ignored
- TIMEOUT_CYCLES, 255, cycle limit for the watchdog (used only with the macro; at most 2^16-1)

Ports:
- clk_i  in  1  clock; all state on rising edge
- rst_i  in  1  reset, asynchronous, active-high
- psel_i  in  1  APB select
- penable_i  in  1  APB enable (access phase)
- pwrite_i  in  1  1 = write
- paddr_i  in  32  byte address
- pwdata_i  in  32  write data
- pstrb_i  in  4  byte strobes (write only)
- prdata_o  out  32  read data, registered
- pready_o  out  1  transfer complete
- pslverr_o  out  1  transfer error
- periph_req_o  out  1  periph request
- periph_gnt_i  in  1  periph grant
- periph_add_o  out  32  periph address
- periph_wen_o  out  1  0 = write, 1 = read
- periph_be_o  out  4  byte enables
- periph_data_o  out  32  write data
- periph_id_o  out  ID  request ID, always ID_VAL
- periph_r_data_i  in  32  response data
- periph_r_valid_i  in  1  response valid
- periph_r_id_i  in  ID  response ID

## Operation
- FSM states: IDLE, REQ, RESP, DONE.
- IDLE:
  - On psel_i=1 (setup phase), latch paddr_i, pwdata_i, and !pwrite_i as wen.
  - Latch be: pstrb_i for writes, 4'hF for reads.
  - Go to REQ.
- REQ:
  - periph_req_o=1, with latched add/wen/be/data stable.
  - Hold until periph_gnt_i=1, then go to RESP.
  - periph_req_o deasserts in the cycle after the grant.
- RESP:
  - Wait for periph_r_valid_i=1 with periph_r_id_i==ID_VAL.
  - On that response, capture r_data into prdata_o (writes capture it too; the value is don't-care) and go to DONE.
  - A response with a mismatched ID is ignored.
- DONE:
  - pready_o=1 for exactly one cycle; pslverr_o=0 on normal completion.
  - Return to IDLE.
  - APB guarantees penable_i=1 by this point; the bridge does not check it.
- Only one transaction is outstanding at a time; there is no pipelining.
- psel_i is ignored outside IDLE.
- A periph response arriving in IDLE, REQ or DONE is ignored.
- periph_add_o is passed through unmodified; no address decode.

## Timing
- Reset values:
  - FSM in IDLE.
  - periph_req_o=0, periph_wen_o=1, periph_add_o=0, periph_be_o=0, periph_data_o=0.
  - prdata_o=0, pready_o=0, pslverr_o=0.
  - Timeout counter=0.
- Reset mid-transaction: outputs return to reset values asynchronously. The periph request is dropped, and a later response is ignored.
- Minimum latency with setup at cycle 0:
  - cycle 1: REQ with gnt=1.
  - cycle 2: RESP with r_valid=1.
  - cycle 3: pready_o=1.
  - Total 4 APB cycles.
- Each gnt wait cycle and each response wait cycle adds exactly one cycle.
- pready_o, pslverr_o and prdata_o are registered outputs. periph_* outputs are registered.

## Configuration
- AES_APB2PERIPH_TIMEOUT_EN defined:
  - A 16-bit counter clears on leaving IDLE and increments each cycle in REQ or RESP.
  - When the counter reaches TIMEOUT_CYCLES, the FSM goes to DONE with pslverr_o=1 and prdata_o=32'h0, and periph_req_o drops.
  - If the timeout and the completing event (gnt in REQ, or matching r_valid in RESP) occur in the same cycle, normal completion wins.
- AES_APB2PERIPH_TIMEOUT_EN undefined:
  - No counter is instantiated.
  - pslverr_o is tied to 0.
  - The bridge waits indefinitely.

## Structure
- aes_package holds:
  - the FSM state enum aes_apb2periph_state_t;
  - the constant AES_APB2PERIPH_ERR_DATA (32'h0).
- One sub-module: aes_apb2periph_timeout, the clear/enable counter with a terminal-count flag. It is instantiated only under the macro.

## Test plan
- Write, zero wait: APB write addr 0x20, data 0xA5A5_0001, strb 4'hF, gnt and r_valid immediate.
  - Expect periph_req_o=1 for exactly 1 cycle, wen=0, be=4'hF.
  - Expect pready_o=1 at cycle 3, pslverr_o=0.
- Read with waits: read addr 0x04, gnt after 3 cycles, r_valid 2 cycles later with r_data 0x0000_00C3.
  - Expect req held 4 cycles, wen=1, be=4'hF.
  - Expect pready_o=1 at cycle 8 with prdata_o=0x0000_00C3.
- ID filter: read; first response with r_id=ID_VAL+1 and data 0xBAD, then matching ID and data 0x5A.
  - Expect prdata_o=0x5A and pready_o only after the matching response.
- Reset in RESP: assert rst_i during RESP.
  - Expect all outputs at reset values in the same cycle.
  - A subsequent r_valid causes no pready_o.
  - The next APB write completes normally.
- Timeout (macro defined, TIMEOUT_CYCLES=8): gnt never asserted.
  - Expect pready_o=1 and pslverr_o=1 after 8 REQ cycles, and periph_req_o low afterwards.
- Partial strobe: write with pstrb_i=4'b0110.
  - Expect periph_be_o=4'b0110; a following read drives be=4'hF.

Source files
------------

// File: rtl/aes_package.sv
// Shared FSM state type and error read-data constant for the APB-to-periph bridge.
package aes_package;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2,
    DONE = 2'd3
  } aes_apb2periph_state_t;

  localparam logic [31:0] AES_APB2PERIPH_ERR_DATA = 32'h0000_0000;

endpackage

// File: rtl/aes_apb2periph_timeout.sv
// Watchdog counter: cleared on request, counts while enabled, flags the cycle whose
// increment would reach LIMIT. Used only when AES_APB2PERIPH_TIMEOUT_EN is defined.
module aes_apb2periph_timeout #(
  parameter int LIMIT = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);

  logic [15:0] r_cnt;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cnt <= 16'd0;
    end else if (i_clr) begin
      r_cnt <= 16'd0;
    end else if (i_en) begin
      r_cnt <= r_cnt + 16'd1;
    end
  end

  // Flag on the last waiting cycle so exactly LIMIT REQ/RESP cycles elapse before DONE.
  assign o_tc = i_en && (r_cnt == 16'(LIMIT - 1));

endmodule

// File: rtl/aes_apb2periph.sv
// APB3 slave to HWPE periph bridge, one periph transaction per APB transfer.
// Optional watchdog enabled by defining AES_APB2PERIPH_TIMEOUT_EN.
module aes_apb2periph
  import aes_package::*;
#(
  parameter int ID             = 10,
  parameter int ID_VAL         = 1,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          psel_i,
  input  logic          penable_i,
  input  logic          pwrite_i,
  input  logic [31:0]   paddr_i,
  input  logic [31:0]   pwdata_i,
  input  logic [3:0]    pstrb_i,
  output logic [31:0]   prdata_o,
  output logic          pready_o,
  output logic          pslverr_o,
  output logic          periph_req_o,
  input  logic          periph_gnt_i,
  output logic [31:0]   periph_add_o,
  output logic          periph_wen_o,
  output logic [3:0]    periph_be_o,
  output logic [31:0]   periph_data_o,
  output logic [ID-1:0] periph_id_o,
  input  logic [31:0]   periph_r_data_i,
  input  logic          periph_r_valid_i,
  input  logic [ID-1:0] periph_r_id_i
);

  aes_apb2periph_state_t r_state, w_state_nxt;

  logic        r_req, r_wen, r_pready;
  logic [31:0] r_add, r_data, r_prdata;
  logic [3:0]  r_be;

  logic        w_req_nxt, w_pready_nxt, w_latch, w_to_err, w_tc, w_resp_hit;
  logic [31:0] w_prdata_nxt;

  assign w_resp_hit = periph_r_valid_i && (periph_r_id_i == ID'(ID_VAL));

`ifdef AES_APB2PERIPH_TIMEOUT_EN
  logic r_pslverr;

  aes_apb2periph_timeout #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .i_clr ((r_state == IDLE) && psel_i),
    .i_en  ((r_state == REQ) || (r_state == RESP)),
    .o_tc  (w_tc)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_pslverr <= 1'b0;
    else       r_pslverr <= w_to_err;
  end

  assign pslverr_o = r_pslverr;
  logic w_unused;
  assign w_unused = penable_i;
`else
  assign w_tc      = 1'b0;
  assign pslverr_o = 1'b0;
  logic w_unused;
  assign w_unused = ^{penable_i, w_to_err, (TIMEOUT_CYCLES != 0)};
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state  <= IDLE;
      r_req    <= 1'b0;
      r_pready <= 1'b0;
      r_prdata <= 32'h0000_0000;
    end else begin
      r_state  <= w_state_nxt;
      r_req    <= w_req_nxt;
      r_pready <= w_pready_nxt;
      r_prdata <= w_prdata_nxt;
    end
  end

  // Request fields are captured in the APB setup phase and held until the next transfer.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_add  <= 32'h0000_0000;
      r_data <= 32'h0000_0000;
      r_wen  <= 1'b1;
      r_be   <= 4'h0;
    end else if (w_latch) begin
      r_add  <= paddr_i;
      r_data <= pwdata_i;
      r_wen  <= ~pwrite_i;
      r_be   <= pwrite_i ? pstrb_i : 4'hF;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_req_nxt    = r_req;
    w_pready_nxt = 1'b0;
    w_prdata_nxt = r_prdata;
    w_latch      = 1'b0;
    w_to_err     = 1'b0;
    case (r_state)
      IDLE: begin
        if (psel_i) begin
          w_latch     = 1'b1;
          w_req_nxt   = 1'b1;
          w_state_nxt = REQ;
        end
      end
      REQ: begin
        // A grant in the terminal-count cycle still completes normally.
        if (periph_gnt_i) begin
          w_req_nxt   = 1'b0;
          w_state_nxt = RESP;
        end else if (w_tc) begin
          w_req_nxt    = 1'b0;
          w_pready_nxt = 1'b1;
          w_to_err     = 1'b1;
          w_prdata_nxt = AES_APB2PERIPH_ERR_DATA;
          w_state_nxt  = DONE;
        end
      end
      RESP: begin
        if (w_resp_hit) begin
          w_pready_nxt = 1'b1;
          w_prdata_nxt = periph_r_data_i;
          w_state_nxt  = DONE;
        end else if (w_tc) begin
          w_pready_nxt = 1'b1;
          w_to_err     = 1'b1;
          w_prdata_nxt = AES_APB2PERIPH_ERR_DATA;
          w_state_nxt  = DONE;
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_req_nxt   = 1'b0;
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign prdata_o      = r_prdata;
  assign pready_o      = r_pready;
  assign periph_req_o  = r_req;
  assign periph_add_o  = r_add;
  assign periph_wen_o  = r_wen;
  assign periph_be_o   = r_be;
  assign periph_data_o = r_data;
  assign periph_id_o   = ID'(ID_VAL);

endmodule

// File: tb/tb_aes_apb2periph.sv
// Self-checking bench for aes_apb2periph: vector table plus reset and timeout sequences.
module tb_aes_apb2periph;

  localparam int ID     = 10;
  localparam int ID_VAL = 1;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          psel_i, penable_i, pwrite_i;
  logic [31:0]   paddr_i, pwdata_i;
  logic [3:0]    pstrb_i;
  logic [31:0]   prdata_o;
  logic          pready_o, pslverr_o;
  logic          periph_req_o, periph_gnt_i;
  logic [31:0]   periph_add_o;
  logic          periph_wen_o;
  logic [3:0]    periph_be_o;
  logic [31:0]   periph_data_o;
  logic [ID-1:0] periph_id_o;
  logic [31:0]   periph_r_data_i;
  logic          periph_r_valid_i;
  logic [ID-1:0] periph_r_id_i;

  aes_apb2periph #(
    .ID             (ID),
    .ID_VAL         (ID_VAL),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .psel_i           (psel_i),
    .penable_i        (penable_i),
    .pwrite_i         (pwrite_i),
    .paddr_i          (paddr_i),
    .pwdata_i         (pwdata_i),
    .pstrb_i          (pstrb_i),
    .prdata_o         (prdata_o),
    .pready_o         (pready_o),
    .pslverr_o        (pslverr_o),
    .periph_req_o     (periph_req_o),
    .periph_gnt_i     (periph_gnt_i),
    .periph_add_o     (periph_add_o),
    .periph_wen_o     (periph_wen_o),
    .periph_be_o      (periph_be_o),
    .periph_data_o    (periph_data_o),
    .periph_id_o      (periph_id_o),
    .periph_r_data_i  (periph_r_data_i),
    .periph_r_valid_i (periph_r_valid_i),
    .periph_r_id_i    (periph_r_id_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    int          gw;
    int          rw;
    logic [31:0] rdata;
    logic        bad_id;
    logic [3:0]  exp_be;
    logic        exp_wen;
    int          exp_req;
    int          exp_rdy;
  } vec_t;

  typedef struct {
    logic [31:0] prdata;
    logic        err;
    int          rdy_cyc;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[6];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    psel_i = 1'b0; penable_i = 1'b0; pwrite_i = 1'b0;
    paddr_i = 32'h0; pwdata_i = 32'h0; pstrb_i = 4'h0;
    periph_gnt_i = 1'b0; periph_r_valid_i = 1'b0;
    periph_r_data_i = 32'h0; periph_r_id_i = ID'(ID_VAL);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req"},    {31'h0, periph_req_o}, 32'h0);
    chk({tag, "_wen"},    {31'h0, periph_wen_o}, 32'h1);
    chk({tag, "_add"},    periph_add_o,          32'h0);
    chk({tag, "_be"},     {28'h0, periph_be_o},  32'h0);
    chk({tag, "_data"},   periph_data_o,         32'h0);
    chk({tag, "_prdata"}, prdata_o,              32'h0);
    chk({tag, "_pready"}, {31'h0, pready_o},     32'h0);
    chk({tag, "_pslverr"},{31'h0, pslverr_o},    32'h0);
  endtask

  // Pops the scoreboard entry for a completed transfer and compares it.
  task automatic sb_check(input string tag, input int cyc);
    exp_t e;
    n_cmp++;
    if (sb.size() == 0) begin
      n_bad++;
      $display("FAIL %s_sb_empty: got pready with no expected entry, want none", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, "_prdata"},  prdata_o,            e.prdata);
      chk({tag, "_pslverr"}, {31'h0, pslverr_o},  {31'h0, e.err});
      chk({tag, "_rdy_cyc"}, cyc,                 e.rdy_cyc);
    end
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int req_cnt;
    int rdy_at;
    req_cnt = 0;
    rdy_at  = -1;
    @(posedge clk_i); #1;
    idle_inputs();
    psel_i = 1'b1; pwrite_i = v.wr; paddr_i = v.addr; pwdata_i = v.wdata; pstrb_i = v.strb;
    sb.push_back('{v.rdata, 1'b0, v.exp_rdy});
    for (int c = 1; c < 40 && rdy_at < 0; c++) begin
      @(posedge clk_i); #1;
      penable_i        = 1'b1;
      periph_gnt_i     = (c == 1 + v.gw);
      periph_r_valid_i = 1'b0;
      periph_r_id_i    = ID'(ID_VAL);
      periph_r_data_i  = 32'h0;
      if (c == 2 + v.gw + v.rw) begin
        periph_r_valid_i = 1'b1;
        periph_r_data_i  = v.rdata;
      end else if (v.bad_id && c == 1 + v.gw + v.rw) begin
        periph_r_valid_i = 1'b1;
        periph_r_id_i    = ID'(ID_VAL + 1);
        periph_r_data_i  = 32'h0000_0BAD;
      end
      @(negedge clk_i);
      if (periph_req_o) begin
        req_cnt++;
        chk({tag, "_wen"},  {31'h0, periph_wen_o}, {31'h0, v.exp_wen});
        chk({tag, "_be"},   {28'h0, periph_be_o},  {28'h0, v.exp_be});
        chk({tag, "_add"},  periph_add_o,          v.addr);
        chk({tag, "_data"}, periph_data_o,         v.wdata);
        chk({tag, "_id"},   {22'h0, periph_id_o},  32'(ID_VAL));
      end
      if (pready_o) begin
        rdy_at = c;
        sb_check(tag, c);
      end
    end
    chk({tag, "_req_cycles"}, req_cnt, v.exp_req);
    if (rdy_at < 0) begin
      n_cmp++; n_bad++;
      $display("FAIL %s_pready_timeout: got no pready in 40 cycles, want cycle %0d", tag, v.exp_rdy);
    end
    @(posedge clk_i); #1;
    idle_inputs();
    @(negedge clk_i);
    chk({tag, "_pready_one_cycle"}, {31'h0, pready_o}, 32'h0);
  endtask

  initial begin
    vecs[0] = '{1'b1, 32'h20, 32'hA5A5_0001, 4'hF, 0, 0, 32'h1234_5678, 1'b0, 4'hF, 1'b0, 1, 3};
    vecs[1] = '{1'b0, 32'h04, 32'h0,         4'h0, 3, 2, 32'h0000_00C3, 1'b0, 4'hF, 1'b1, 4, 8};
    vecs[2] = '{1'b0, 32'h10, 32'h0,         4'h0, 0, 2, 32'h0000_005A, 1'b1, 4'hF, 1'b1, 1, 5};
    vecs[3] = '{1'b1, 32'h30, 32'hDEAD_BEEF, 4'h6, 1, 0, 32'h0000_0077, 1'b0, 4'h6, 1'b0, 2, 4};
    vecs[4] = '{1'b0, 32'h34, 32'h0,         4'h6, 0, 1, 32'hCAFE_0001, 1'b0, 4'hF, 1'b1, 1, 4};
    vecs[5] = '{1'b1, 32'h3C, 32'h0BAD_F00D, 4'h9, 2, 3, 32'h0000_0011, 1'b0, 4'h9, 1'b0, 3, 8};

    idle_inputs();
    rst_i = 1'b1;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    check_reset_outputs("reset");
    @(posedge clk_i); #1;
    rst_i = 1'b0;

    for (int i = 0; i < 6; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
    end

    // Reset during RESP, then a stray response must not complete anything.
    @(posedge clk_i); #1;
    psel_i = 1'b1; pwrite_i = 1'b0; paddr_i = 32'h44;
    @(posedge clk_i); #1;
    penable_i = 1'b1; periph_gnt_i = 1'b1;
    @(posedge clk_i); #1;
    periph_gnt_i = 1'b0;
    @(negedge clk_i);
    chk("rst_pre_add", periph_add_o, 32'h44);
    #1 rst_i = 1'b1;
    #1 check_reset_outputs("rst_resp");
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    idle_inputs();
    periph_r_valid_i = 1'b1;
    periph_r_data_i  = 32'h0000_00EE;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk_i);
      chk("rst_stray_pready", {31'h0, pready_o}, 32'h0);
    end
    @(posedge clk_i); #1;
    idle_inputs();
    run_vec(vecs[0], "post_rst");

`ifdef AES_APB2PERIPH_TIMEOUT_EN
    begin
      int req_cnt;
      int rdy_at;
      req_cnt = 0;
      rdy_at  = -1;
      @(posedge clk_i); #1;
      psel_i = 1'b1; pwrite_i = 1'b0; paddr_i = 32'h08;
      sb.push_back('{32'h0, 1'b1, 9});
      for (int c = 1; c < 30 && rdy_at < 0; c++) begin
        @(posedge clk_i); #1;
        penable_i = 1'b1;
        @(negedge clk_i);
        if (periph_req_o) req_cnt++;
        if (pready_o) begin
          rdy_at = c;
          sb_check("timeout", c);
        end
      end
      chk("timeout_req_cycles", req_cnt, 8);
      if (rdy_at < 0) begin
        n_cmp++; n_bad++;
        $display("FAIL timeout_pready: got no pready in 30 cycles, want cycle 9");
      end
      @(posedge clk_i); #1;
      idle_inputs();
      @(negedge clk_i);
      chk("timeout_req_after", {31'h0, periph_req_o}, 32'h0);
      chk("timeout_pready_after", {31'h0, pready_o}, 32'h0);
    end
`endif

    chk("sb_drained", sb.size(), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
